uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   Serial receive stage feeding the APB register block. Synchronises the rx pin and detects
//   the start bit, then samples mid-bit for 5-8 data bits, optional parity and 1/2 stop bits.
//   Presents the received byte plus error flags in a one-entry holding buffer, read at offset
//   0x04. Drives rts_n flow control from buffer occupancy.
// PARAMETERS
//   TRANS_DATA_WIDTH  8      width of rx_data (max data bits per frame)
//   CLKS_PER_BIT      10416  clk cycles per bit (100 MHz / 9600 baud)
//   SYNC_STAGES       2      flops in the rx synchroniser
// PORTS
//   clk              in   1   receive clock
//   rst_n            in   1   asynchronous reset, active low
//   rx               in   1   serial input, idle high, asynchronous
//   cfg_data_bit     in   2   0=5, 1=6, 2=7, 3=8 data bits
//   cfg_stop_bit     in   1   0=1 stop bit, 1=2 stop bits
//   cfg_parity_en    in   1   1=parity bit present
//   cfg_parity_type  in   1   1=even, 0=odd
//   rx_ack           in   1   1-cycle pulse: buffer read by register block
//   rx_data          out  8   received byte, LSB = first bit, unused MSBs zero
//   rx_valid         out  1   holding buffer full (status bit1)
//   rx_done          out  1   1-cycle pulse at end of each frame
//   parity_err       out  1   parity mismatch in the buffered frame
//   frame_err        out  1   stop bit sampled low in the buffered frame
//   overrun_err      out  1   frame arrived while buffer still full (sticky)
//   rx_busy          out  1   state != IDLE
//   rts_n            out  1   =rx_valid; high means do not send
// BEHAVIOUR
// - Reset: all outputs 0 except rts_n=0. Synchroniser flops reset to 1. FSM goes to IDLE.
//   Assertion mid-frame discards the partial frame.
// - FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
//   - IDLE: a synced falling edge latches the cfg_* inputs. Go to START, counter loads
//     CLKS_PER_BIT/2-1. Cfg changes mid-frame are ignored.
//   - START: at counter 0, sample rx. If 1 (glitch), go back to IDLE with no flags. If 0, go
//     to DATA; counter reloads CLKS_PER_BIT-1 on every bit from here on.
//   - DATA: shift the sample into bit index [i], i from 0 to N-1 with N=5+cfg_data_bit.
//     After bit N-1, go to PARITY if parity is enabled, else STOP1.
//   - PARITY: expected bit = ^data for even, ~^data for odd. A mismatch sets an internal
//     p_err.
//   - STOP1: a sample of 0 sets f_err. Go to STOP2 if 2 stop bits, else finish.
//   - STOP2: same check as STOP1, then finish.
//   - Finish happens at the mid-bit sample of the last stop bit. The next cycle pulses
//     rx_done, loads rx_data, parity_err and frame_err, and sets rx_valid.
//   - After finish: go to IDLE if rx=1. If f_err and rx=0 (break), go to WAIT_HIGH until
//     rx=1, so a break never re-triggers.
// - Buffer:
//   - rx_ack clears rx_valid, parity_err, frame_err and overrun_err.
//   - rx_done while rx_valid=1 and no rx_ack sets overrun_err; the new data overwrites.
//   - rx_done and rx_ack in the same cycle: rx_valid stays 1, no overrun, new data loaded.
// - Latency: rx_done fires 1 clk after the mid-sample of the last stop bit, i.e.
//   (1+N+P+S-0.5)*CLKS_PER_BIT+SYNC_STAGES+1 clk after the start edge.
// STRUCTURE
// - Shared package uart_pkg: CFG_5/6/7/8_BIT, STOP_BIT_1/2, PARITY_EVEN=1/ODD=0, the rx
//   state enum, and the register offsets (0x04 RX, 0x08 CFG, 0x10 STATUS).
// - Sub-module uart_bit_timer: loadable down-counter with half-bit and full-bit reload and a
//   tick pulse at 0. The bit counter, shift register and buffer stay in uart_rx_core.
// TESTING
// - 8N1, rx frame 0x49 at 10416 clk/bit -> rx_done once; rx_data=0x49; all err=0; rts_n=1
//   until rx_ack.
// - 8E1, 0xB6 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 ->
//   parity_err=1, rx_data=0xB6.
// - 5N2, 0xFF (sends 0x1F) -> rx_data=0x1F. Second stop bit driven 0 -> frame_err=1.
// - Two 8N1 frames with no rx_ack -> overrun_err=1, rx_data=second byte. rx_ack clears all.
// - rx low pulse of 3000 clk -> no rx_done, FSM back in IDLE. Rx low for 12 bit times ->
//   one rx_done with frame_err=1, rx_data=0x00, no second frame.
// - rst_n low during DATA bit 3 -> outputs at reset values. A following full frame
//   0xA5 (7O2) -> rx_data=0x25, parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: configuration encodings, receive FSM states and
// register offsets used by the APB register block.
package uart_pkg;

  localparam logic [1:0] CFG_5_BIT = 2'd0;
  localparam logic [1:0] CFG_6_BIT = 2'd1;
  localparam logic [1:0] CFG_7_BIT = 2'd2;
  localparam logic [1:0] CFG_8_BIT = 2'd3;

  localparam logic STOP_BIT_1 = 1'b0;
  localparam logic STOP_BIT_2 = 1'b1;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

  localparam logic [7:0] REG_RX_OFFSET     = 8'h04;
  localparam logic [7:0] REG_CFG_OFFSET    = 8'h08;
  localparam logic [7:0] REG_STATUS_OFFSET = 8'h10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef struct packed {
    logic [1:0] data_bit;
    logic       stop_bit;
    logic       parity_en;
    logic       parity_type;
  } rx_cfg_t;

  // Number of data bits in a frame for a cfg_data_bit encoding.
  function automatic logic [3:0] data_bits(input logic [1:0] cfg);
    return 4'd5 + {2'b00, cfg};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter pacing the receiver: half-bit reload to reach the
// middle of the start bit, full-bit reload between samples, tick at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop in the design samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_half) begin
      count <= HALF_RELOAD;
    end else if (load_full) begin
      count <= FULL_RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Parks at zero between frames; the FSM ignores tick while idle.
  assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive stage: rx synchroniser, start detect, mid-bit sampling of
// 5-8 data bits, optional parity, 1/2 stop bits, one-entry holding buffer.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int TRANS_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 10416,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic [1:0]                  cfg_data_bit,
  input  logic                        cfg_stop_bit,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_type,
  input  logic                        rx_ack,
  output logic [TRANS_DATA_WIDTH-1:0] rx_data,
  output logic                        rx_valid,
  output logic                        rx_done,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic                        rx_busy,
  output logic                        rts_n
);

  localparam int IDXW = $clog2(TRANS_DATA_WIDTH);

  rx_state_e                 state, state_n;
  rx_cfg_t                   cfg_q;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s, rx_prev, fall;
  logic [IDXW-1:0]           bit_idx, last_idx;
  logic [TRANS_DATA_WIDTH-1:0] shift_q;
  logic                      p_err_q, f_err_q, exp_par;
  logic                      tick, load_half, load_full;
  logic                      latch_cfg, shift_en, par_chk, stop_chk, finish;

  // NOTE: the synchroniser resets to 1 (idle line) so leaving reset can never
  // look like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_prev & ~rx_s;
  assign last_idx = IDXW'(data_bits(cfg_q.data_bit) - 4'd1);
  // Unused MSBs of shift_q are zero, so reducing the full width is exact.
  assign exp_par  = (cfg_q.parity_type == PARITY_EVEN) ? ^shift_q : ~^shift_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_half (load_half),
    .load_full (load_full),
    .tick      (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_n;
  end

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    load_half = 1'b0;
    load_full = 1'b0;
    latch_cfg = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    finish    = 1'b0;
    case (state)
      RX_IDLE: if (fall) begin
        latch_cfg = 1'b1;
        load_half = 1'b1;
        state_n   = RX_START;
      end
      RX_START: if (tick) begin
        if (rx_s) begin
          state_n = RX_IDLE;
        end else begin
          load_full = 1'b1;
          state_n   = RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        shift_en  = 1'b1;
        load_full = 1'b1;
        if (bit_idx == last_idx) state_n = cfg_q.parity_en ? RX_PARITY : RX_STOP1;
      end
      RX_PARITY: if (tick) begin
        par_chk   = 1'b1;
        load_full = 1'b1;
        state_n   = RX_STOP1;
      end
      RX_STOP1: if (tick) begin
        stop_chk = 1'b1;
        if (cfg_q.stop_bit == STOP_BIT_2) begin
          load_full = 1'b1;
          state_n   = RX_STOP2;
        end else begin
          finish  = 1'b1;
          state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_STOP2: if (tick) begin
        stop_chk = 1'b1;
        finish   = 1'b1;
        state_n  = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      // A held-low line (break) must return high before a new start counts.
      RX_WAIT_HIGH: if (rx_s) state_n = RX_IDLE;
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      p_err_q <= 1'b0;
      f_err_q <= 1'b0;
    end else begin
      if (latch_cfg) begin
        cfg_q   <= '{data_bit: cfg_data_bit, stop_bit: cfg_stop_bit,
                     parity_en: cfg_parity_en, parity_type: cfg_parity_type};
        bit_idx <= '0;
        shift_q <= '0;
        p_err_q <= 1'b0;
        f_err_q <= 1'b0;
      end
      if (shift_en) begin
        shift_q[bit_idx] <= rx_s;
        bit_idx          <= bit_idx + IDXW'(1);
      end
      if (par_chk)           p_err_q <= (rx_s != exp_par);
      if (stop_chk && !rx_s) f_err_q <= 1'b1;
    end
  end

  // Holding buffer: an ack and a new frame on the same edge keep it full
  // with the new frame and no overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done <= finish;
      if (rx_ack) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (finish) begin
        rx_data    <= shift_q;
        parity_err <= p_err_q;
        frame_err  <= f_err_q | ~rx_s;
        rx_valid   <= 1'b1;
        if (rx_valid && !rx_ack) overrun_err <= 1'b1;
      end
    end
  end

  assign rx_busy = (state != RX_IDLE);
  assign rts_n   = rx_valid;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a frame-level model predicts when each
// frame completes and what the buffer holds; outputs compared every cycle.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, rx, rx_ack;
  logic [1:0] cfg_data_bit;
  logic       cfg_stop_bit, cfg_parity_en, cfg_parity_type;
  logic [7:0] rx_data;
  logic       rx_valid, rx_done, parity_err, frame_err, overrun_err, rx_busy, rts_n;

  always #5 clk = ~clk;

  uart_rx_core #(.TRANS_DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx              (rx),
    .cfg_data_bit    (cfg_data_bit),
    .cfg_stop_bit    (cfg_stop_bit),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_type (cfg_parity_type),
    .rx_ack          (rx_ack),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_done         (rx_done),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun_err     (overrun_err),
    .rx_busy         (rx_busy),
    .rts_n           (rts_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: completion cycle and buffered contents per frame.
  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  logic       ack_q = 1'b0;
  logic       m_valid = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         busy_lo = 1, busy_hi = 0;
  int         last_lat = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ack_q <= rx_ack;
  end

  always @(negedge clk) begin : compare
    logic        exp_done, exp_busy;
    logic [14:0] exp_vec, act_vec;
    exp_done = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
      exp_q.delete();
      busy_lo = 1;
      busy_hi = 0;
    end else begin
      if (ack_q) begin
        m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (m_valid && !ack_q) m_ovr = 1'b1;
        m_valid  = 1'b1;
        m_data   = exp_q[0].data;
        m_pe     = exp_q[0].pe;
        m_fe     = exp_q[0].fe;
        exp_done = 1'b1;
        void'(exp_q.pop_front());
      end
    end
    exp_busy = rst_n && (cyc >= busy_lo) && (cyc <= busy_hi);
    exp_vec  = {m_data, m_valid, exp_done, m_pe, m_fe, m_ovr, exp_busy, m_valid};
    act_vec  = {rx_data, rx_valid, rx_done, parity_err, frame_err, overrun_err, rx_busy, rts_n};
    check($sformatf("outputs{data,valid,done,pe,fe,ovr,busy,rts_n} cyc %0d", cyc), 32'(act_vec), 32'(exp_vec));
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit par_en, input bit par_even,
                            input logic par_bit, input int nstop, input logic [1:0] stop_lv);
    exp_t       e;
    int         k, c0, ones;
    logic [7:0] dm;
    logic       last_low;
    cfg_data_bit    = 2'(n - 5);
    cfg_parity_en   = par_en;
    cfg_parity_type = par_even;
    cfg_stop_bit    = (nstop == 2);
    dm       = d & 8'((1 << n) - 1);
    ones     = $countones(dm) + (par_en ? int'(par_bit) : 0);
    k        = n + (par_en ? 1 : 0) + nstop;
    last_low = (nstop == 2) ? !stop_lv[1] : !stop_lv[0];
    c0       = cyc;
    e.cyc    = c0 + (2 * k + 1) * CPB / 2 + SYNC + 1;
    e.data   = dm;
    e.pe     = par_en && ((ones % 2) != (par_even ? 0 : 1));
    e.fe     = !stop_lv[0] || (nstop == 2 && !stop_lv[1]);
    exp_q.push_back(e);
    last_lat = e.cyc - c0;
    busy_lo  = c0 + SYNC + 1;
    busy_hi  = last_low ? c0 + (k + 1) * CPB + SYNC : e.cyc - 1;
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(dm[i]);
    if (par_en) drive_bit(par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(stop_lv[i]);
    drive_bit(1'b1);
  endtask

  task automatic send_break(input int nbits_low);
    exp_t e;
    int   c0;
    cfg_data_bit  = 2'd3;
    cfg_parity_en = 1'b0;
    cfg_stop_bit  = 1'b0;
    c0       = cyc;
    e.cyc    = c0 + (2 * 9 + 1) * CPB / 2 + SYNC + 1;
    e.data   = 8'h00;
    e.pe     = 1'b0;
    e.fe     = 1'b1;
    exp_q.push_back(e);
    busy_lo  = c0 + SYNC + 1;
    busy_hi  = c0 + nbits_low * CPB + SYNC;
    rx = 1'b0;
    step(nbits_low * CPB);
    rx = 1'b1;
    step(2 * CPB);
  endtask

  task automatic send_glitch(input int low_clks);
    int c0;
    c0      = cyc;
    busy_lo = c0 + SYNC + 1;
    busy_hi = c0 + SYNC + CPB / 2;
    rx = 1'b0;
    step(low_clks);
    rx = 1'b1;
    step(2 * CPB);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; rx_ack = 1'b0;
    cfg_data_bit = 2'd3; cfg_stop_bit = 1'b0; cfg_parity_en = 1'b0; cfg_parity_type = 1'b0;
    step(3);
    check("rst_rts_n", 32'(rts_n), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_busy", 32'(rx_busy), 0);
    check("rst_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    step(4);

    // 8N1 0x49
    send_frame(8'h49, 8, 0, 0, 1'b0, 1, 2'b11);
    check("lat_8n1_model", last_lat, 155);
    check("f49_model_data", 32'(m_data), 32'h49);
    check("f49_data", 32'(rx_data), 32'h49);
    check("f49_rts_n", 32'(rts_n), 1);
    check("f49_errs", 32'({parity_err, frame_err, overrun_err}), 0);
    ack();
    check("f49_ack_rts_n", 32'(rts_n), 0);

    // 8E1 0xB6, correct then wrong parity bit
    send_frame(8'hB6, 8, 1, 1, 1'b1, 1, 2'b11);
    check("b6_good_model_pe", 32'(m_pe), 0);
    check("b6_good_pe", 32'(parity_err), 0);
    ack();
    send_frame(8'hB6, 8, 1, 1, 1'b0, 1, 2'b11);
    check("b6_bad_model_pe", 32'(m_pe), 1);
    check("b6_bad_pe", 32'(parity_err), 1);
    check("b6_bad_data", 32'(rx_data), 32'hB6);
    ack();

    // 5N2 0xFF, then second stop bit low
    send_frame(8'hFF, 5, 0, 0, 1'b0, 2, 2'b11);
    check("lat_5n2_model", last_lat, 123);
    check("5n2_data", 32'(rx_data), 32'h1F);
    check("5n2_fe", 32'(frame_err), 0);
    ack();
    send_frame(8'hFF, 5, 0, 0, 1'b0, 2, 2'b01);
    check("5n2_stop2_model_fe", 32'(m_fe), 1);
    check("5n2_stop2_fe", 32'(frame_err), 1);
    ack();

    // Overrun: two frames without ack
    send_frame(8'h3C, 8, 0, 0, 1'b0, 1, 2'b11);
    send_frame(8'hC3, 8, 0, 0, 1'b0, 1, 2'b11);
    check("ovr_flag", 32'(overrun_err), 1);
    check("ovr_data", 32'(rx_data), 32'hC3);
    ack();
    check("ovr_ack_clear", 32'({rx_valid, parity_err, frame_err, overrun_err}), 0);

    // Short low pulse is rejected at the start-bit sample
    send_glitch(5);
    check("glitch_busy", 32'(rx_busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);

    // Break: line low for 12 bit times
    send_break(12);
    check("break_fe", 32'(frame_err), 1);
    check("break_data", 32'(rx_data), 0);
    check("break_busy", 32'(rx_busy), 0);

    // Reset in the middle of data bit 3 of a 7O2 frame
    cfg_data_bit = 2'd2; cfg_parity_en = 1'b1; cfg_parity_type = 1'b0; cfg_stop_bit = 1'b1;
    busy_lo = cyc + SYNC + 1;
    busy_hi = cyc + 100000;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    step(CPB / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    step(3);
    check("midrst_busy", 32'(rx_busy), 0);
    check("midrst_valid_fe", 32'({rx_valid, frame_err}), 0);
    check("midrst_rts_n", 32'(rts_n), 0);
    rst_n = 1'b1;
    step(2 * CPB);

    // Full 7O2 0xA5 after reset
    send_frame(8'hA5, 7, 1, 0, 1'b0, 2, 2'b11);
    check("a5_data", 32'(rx_data), 32'h25);
    check("a5_pe", 32'(parity_err), 0);
    check("a5_ovr", 32'(overrun_err), 0);
    ack();
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
